regfile_wr_arbiter: RTL and testbench

- Owns the single write port (we3/a3/wd3) of the 15-entry processor register file.
- Shares that port between two write-back requesters: port A (ALU result) and port B (load data). B has fixed priority, with a starvation bound protecting A.
- Keeps a pending-write scoreboard (busy mask) so decode can stall on operands whose write-back is outstanding.
- Sits between the execute/memory stages and the register file.

---
 rtl/regfile_wr_arbiter.sv | 89 ++++++++
 tb/tb_regfile_wr_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// Write-port arbiter for the 15-entry register file: B-priority with a starvation
// bound for A, registered write stage, R15 discard, and pending-write scoreboard.
module regfile_wr_arbiter #(
  parameter int STARVE_MAX = 3,
  parameter int WIDTH      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [3:0]       a_addr,
  input  logic [WIDTH-1:0] a_data,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [3:0]       b_addr,
  input  logic [WIDTH-1:0] b_data,
  input  logic             rsv_valid,
  input  logic [3:0]       rsv_addr,
  input  logic [3:0]       q_addr1,
  input  logic [3:0]       q_addr2,
  output logic             q_stall,
  output logic [14:0]      busy,
  output logic             we3,
  output logic [3:0]       a3,
  output logic [WIDTH-1:0] wd3,
  output logic             r15_drop
);

  localparam int CW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  logic [CW-1:0]    cnt;
  logic             starved;
  logic             xfer;
  logic [3:0]       x_addr;
  logic [WIDTH-1:0] x_data;
  logic [15:0]      set_mask;
  logic [15:0]      clr_mask;
  logic [15:0]      busy_ext;

  assign starved = (cnt == CNT_MAX);
  assign a_ready = a_valid & (~b_valid | starved);
  assign b_ready = b_valid & ~(a_valid & starved);
  assign xfer    = a_ready | b_ready;
  assign x_addr  = a_ready ? a_addr : b_addr;
  assign x_data  = a_ready ? a_data : b_data;

  // Bit 15 of the masks is the PC slot; it is dropped when applied to busy.
  assign set_mask = rsv_valid ? (16'd1 << rsv_addr) : 16'd0;
  assign clr_mask = we3 ? (16'd1 << a3) : 16'd0;
  assign busy_ext = {1'b0, busy};
  assign q_stall  = busy_ext[q_addr1] | busy_ext[q_addr2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!a_valid || a_ready) begin
      cnt <= '0;
    end else if (b_ready && !starved) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we3      <= 1'b0;
      a3       <= 4'd0;
      wd3      <= '0;
      r15_drop <= 1'b0;
    end else begin
      we3      <= xfer && (x_addr != 4'hF);
      r15_drop <= xfer && (x_addr == 4'hF);
      if (xfer && (x_addr != 4'hF)) begin
        a3  <= x_addr;
        wd3 <= x_data;
      end
    end
  end

  // Set is applied after clear so a new reservation wins over the retiring write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~clr_mask[14:0]) | set_mask[14:0];
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed scenarios plus random traffic against a
// cycle-level reference model of grants, write stage and scoreboard.
module tb_regfile_wr_arbiter;

  localparam int W  = 32;
  localparam int SM = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         a_valid, b_valid, rsv_valid;
  logic         a_ready, b_ready, q_stall, we3, r15_drop;
  logic [3:0]   a_addr, b_addr, rsv_addr, q_addr1, q_addr2, a3;
  logic [W-1:0] a_data, b_data, wd3;
  logic [14:0]  busy;

  regfile_wr_arbiter #(.STARVE_MAX(SM), .WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .q_addr1(q_addr1), .q_addr2(q_addr2), .q_stall(q_stall), .busy(busy),
    .we3(we3), .a3(a3), .wd3(wd3), .r15_drop(r15_drop)
  );

  always #5 clk = ~clk;

  int npass = 0, nfail = 0, ntotal = 0;

  // reference model state
  int         m_cnt;
  bit         m_we, m_drop;
  int         m_a3;
  logic [W-1:0] m_wd;
  bit         m_busy[15];
  bit         last_ga, last_gb;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    m_cnt = 0; m_we = 0; m_drop = 0; m_a3 = 0; m_wd = '0;
    for (int r = 0; r < 15; r++) m_busy[r] = 0;
  endtask

  function automatic logic [14:0] mbusy();
    logic [14:0] v;
    for (int r = 0; r < 15; r++) v[r] = m_busy[r];
    return v;
  endfunction

  // Called just after a falling edge with inputs applied; checks, then advances one cycle.
  task automatic cyc();
    bit ga, gb, stall;
    int ad;
    logic [W-1:0] dt;
    ga = a_valid && (!b_valid || m_cnt == SM);
    gb = b_valid && !ga;
    stall = (q_addr1 < 15 && m_busy[q_addr1]) || (q_addr2 < 15 && m_busy[q_addr2]);
    #1;
    chk("a_ready", a_ready, ga);
    chk("b_ready", b_ready, gb);
    chk("q_stall", q_stall, stall);
    chk("we3", we3, m_we);
    chk("a3", a3, m_a3);
    chk("wd3", wd3, m_wd);
    chk("r15_drop", r15_drop, m_drop);
    chk("busy", busy, mbusy());
    last_ga = ga; last_gb = gb;
    @(posedge clk);
    if (m_we) m_busy[m_a3] = 0;
    if (rsv_valid && rsv_addr != 4'hF) m_busy[rsv_addr] = 1;
    if (ga || gb) begin
      ad = ga ? int'(a_addr) : int'(b_addr);
      dt = ga ? a_data : b_data;
      m_we = (ad != 15);
      m_drop = (ad == 15);
      if (ad != 15) begin m_a3 = ad; m_wd = dt; end
    end else begin
      m_we = 0; m_drop = 0;
    end
    if (!a_valid || ga) m_cnt = 0;
    else if (gb && m_cnt < SM) m_cnt = m_cnt + 1;
    @(negedge clk);
  endtask

  task automatic idle();
    a_valid = 0; b_valid = 0; rsv_valid = 0;
  endtask

  logic [7:0] gpat;

  initial begin
    reset = 1; idle();
    a_addr = 0; b_addr = 0; a_data = 0; b_data = 0;
    rsv_addr = 0; q_addr1 = 0; q_addr2 = 0;
    mreset();
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_we3", we3, 1'b0);
    chk("rst_busy", busy, 15'd0);
    reset = 0;
    @(negedge clk);

    // single requester
    a_valid = 1; a_addr = 3; a_data = 32'h0000_00AA;
    cyc();
    idle();
    #1; chk("single_we3", we3, 1'b1); chk("single_a3", a3, 4'd3); chk("single_wd3", wd3, 32'hAA);
    #1 cyc();
    cyc();

    // contention and starvation bound
    a_valid = 1; b_valid = 1; a_addr = 1; b_addr = 2; a_data = 32'h1111; b_data = 32'h2222;
    gpat = '0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      gpat = {gpat[6:0], last_ga};
    end
    chk("starve_order", gpat, 8'b0001_0001);
    idle(); cyc();

    // scoreboard set, query, clear
    rsv_valid = 1; rsv_addr = 5; cyc();
    rsv_valid = 0; q_addr1 = 5; cyc();
    chk("sb_busy5_set", busy[5], 1'b1);
    b_valid = 1; b_addr = 5; b_data = 32'h5555; cyc();
    b_valid = 0; cyc();
    cyc();
    chk("sb_busy5_clr", busy[5], 1'b0);
    q_addr1 = 0;

    // set/clear collision on R7
    rsv_valid = 1; rsv_addr = 7; cyc();
    rsv_valid = 0; a_valid = 1; a_addr = 7; a_data = 32'h7777; cyc();
    a_valid = 0; rsv_valid = 1; rsv_addr = 7; cyc();
    rsv_valid = 0; #1; chk("collide_busy7", busy[7], 1'b1);
    #1 cyc();

    // R15 discard, R15 reservation and query
    a_valid = 1; a_addr = 4'hF; a_data = 32'hDEAD_BEEF; rsv_valid = 1; rsv_addr = 4'hF; q_addr2 = 4'hF;
    cyc();
    idle();
    #1; chk("r15_we3", we3, 1'b0); chk("r15_drop", r15_drop, 1'b1); chk("r15_stall", q_stall, 1'b0);
    #1 cyc();
    cyc();

    // async reset mid-stream with pending state
    rsv_valid = 1; rsv_addr = 9; a_valid = 1; b_valid = 1; a_addr = 2; b_addr = 4; cyc();
    rsv_valid = 0;
    #2 reset = 1;
    #1;
    chk("midrst_we3", we3, 1'b0);
    chk("midrst_busy", busy, 15'd0);
    chk("midrst_drop", r15_drop, 1'b0);
    mreset();
    @(negedge clk);
    reset = 0;
    b_valid = 0; a_addr = 6; a_data = 32'h600D; cyc();
    idle();
    #1; chk("postrst_we3", we3, 1'b1); chk("postrst_a3", a3, 4'd6);
    #1 cyc();

    // random traffic, requesters hold addr/data while not granted
    for (int i = 0; i < 400; i++) begin
      if (!(a_valid && !last_ga)) begin
        a_valid = ($urandom_range(0, 3) != 0);
        a_addr = 4'($urandom_range(0, 15));
        a_data = $urandom;
      end
      if (!(b_valid && !last_gb)) begin
        b_valid = ($urandom_range(0, 2) != 0);
        b_addr = 4'($urandom_range(0, 15));
        b_data = $urandom;
      end
      rsv_valid = ($urandom_range(0, 1) != 0);
      rsv_addr = 4'($urandom_range(0, 15));
      q_addr1 = 4'($urandom_range(0, 15));
      q_addr2 = 4'($urandom_range(0, 15));
      cyc();
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
